// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU (latency MUL_LAT), DIV/DIVU (restoring radix-2,
// latency WIDTH), and single-cycle MTHI/MTLO. Drives busy for the hazard
// unit and aborts cleanly on flush without touching HI/LO.
// Optional feature: define MDU_MADD_EN to add MADD/MSUB (ops 6/7), which
// run on the multiply path with one extra accumulate cycle.
module mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam int         ACC_LAT  = MUL_LAT + 1;
`else
    localparam int         ACC_LAT  = MUL_LAT;
`endif

    // Counter must hold the longest latency minus one.
    localparam int MAX_LAT = (WIDTH > ACC_LAT) ? WIDTH : ACC_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [1:0]         state;
    logic               busy_q;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_q;
    logic               neg_r;
    logic               div0_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Request decode
    logic is_mul;
    logic is_div;
    logic accept;
    logic a_neg;
    logic b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef MDU_MADD_EN
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_MADD) || (op == OP_MSUB);
`else
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign accept = start && !busy_q && !flush;

    // Divide works on magnitudes; signs are restored in the final cycle.
    assign a_neg = (op == OP_DIV) && a[WIDTH-1];
    assign b_neg = (op == OP_DIV) && b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // Multiply datapath: sign/zero-extend latched operands to 2*WIDTH.
    logic                 mul_signed;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   prod;

    assign mul_signed = (op_q != OP_MULTU);
    assign ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    // One restoring-divide step: shift in the next dividend bit, try subtract.
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign div_ge    = ~div_trial[WIDTH];
    assign rem_nx    = div_ge ? div_trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_nx    = {quo_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   div_hi;
    logic [WIDTH-1:0]   div_lo;

    // Final-cycle results: accumulate for MADD/MSUB, sign fix-up and corner cases for divide.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        mul_res = prod;
`ifdef MDU_MADD_EN
        if (op_q == OP_MADD) begin
            mul_res = {hi_q, lo_q} + prod;
        end else if (op_q == OP_MSUB) begin
            mul_res = {hi_q, lo_q} - prod;
        end
`endif
        div_hi = neg_r ? -rem_nx : rem_nx;
        div_lo = neg_q ? -quo_nx : quo_nx;
        if (div0_q) begin
            div_hi = a_q;
            div_lo = '1;
        end else if (ovf_q) begin
            div_hi = '0;
            div_lo = a_q;
        end
    end

    // Control FSM, latency counter, operand latches and divide iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, because a reset must clear counters and operand latches.
        if (!rst_n) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (busy_q) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            if (flush) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                if (state == S_DIV) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                end
                if (cnt == '0) begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end else if (accept && (is_mul || is_div)) begin
            state  <= is_div ? S_DIV : S_MUL;
            busy_q <= 1'b1;
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            rem_q  <= '0;
            quo_q  <= mag_a;
            dvs_q  <= mag_b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0_q <= (b == '0);
            ovf_q  <= (op == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            if (is_div) begin
                cnt <= CW'(WIDTH - 1);
            end else if (op == OP_MULT || op == OP_MULTU) begin
                cnt <= CW'(MUL_LAT - 1);
            end else begin
                cnt <= CW'(ACC_LAT - 1);
            end
        end
    end

    // HI/LO: written on completion of a multi-cycle op, or directly by MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (busy_q && !flush && cnt == '0) begin
            if (state == S_DIV) begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end else begin
                hi_q <= mul_res[2*WIDTH-1:WIDTH];
                lo_q <= mul_res[WIDTH-1:0];
            end
        end else if (accept && op == OP_MTHI) begin
            hi_q <= a;
        end else if (accept && op == OP_MTLO) begin
            lo_q <= a;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu at default parameters (WIDTH=32, MUL_LAT=5).
// Expected {HI,LO} is computed by a behavioural model at issue, queued, and
// compared when the operation completes; busy duration is checked too.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference for the resulting {HI,LO}.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sx, sy, p;
        int     qi, ri;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0: begin p = sx * sy; return p; end
            4'd1: return {32'd0, x} * {32'd0, y};
            4'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {ri, qi};
            end
            4'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {r, q};
            end
            4'd4: return {x, l};
            4'd5: return {h, x};
`ifdef MDU_MADD_EN
            4'd6: begin p = sx * sy; return {h, l} + p; end
            4'd7: begin p = sx * sy; return {h, l} - p; end
`endif
            default: return {h, l};
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: return 5;
            4'd2, 4'd3: return 32;
`ifdef MDU_MADD_EN
            4'd6, 4'd7: return 6;
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op at a negedge, scramble the operand inputs after acceptance,
    // then wait (bounded) for completion and compare against the queued result.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int n;
        logic [63:0] e;
        e   = model(o, x, y, hi_m, lo_m);
        lat = latency(o);
        exp_q.push_back(e);
        chk("idle_before", {63'd0, busy}, 64'd0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("busy_len op%0d", o), 64'(n), 64'(lat));
        chk($sformatf("hilo op%0d", o), {hi, lo}, exp_q.pop_front());
        hi_m = e[63:32];
        lo_m = e[31:0];
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed multiply and divide cases
        run_op(4'd0, 32'hFFFF_FFFF, 32'd2);
        run_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(4'd3, 32'd7, 32'd2);
        run_op(4'd3, 32'h1234, 32'd0);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(4'd2, 32'hFFFF_FF00, 32'd0);
        run_op(4'd0, 32'h8000_0000, 32'h8000_0000);
        run_op(4'd12, 32'h5A5A_5A5A, 32'd1);

        // Random mix of multiply/divide ops, occasionally dividing by zero
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(4'($urandom_range(0, 3)), $urandom, rb);
        end

        // MTHI/MTLO, then a DIV that is hit by ignored starts and a flush
        run_op(4'd4, 32'hAA, 32'd0);
        run_op(4'd5, 32'hBB, 32'd0);
        start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 4'd5; a = 32'h55;
        @(negedge clk);
        op = 4'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_at_cycle10", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo", {hi, lo}, {32'hAA, 32'hBB});
        repeat (3) @(negedge clk);
        chk("flush_stays_idle", {63'd0, busy}, 64'd0);

        // Start together with flush is dropped
        start = 1'b1; op = 4'd3; a = 32'd9; b = 32'd2; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", {63'd0, busy}, 64'd0);
        chk("start_flush_hilo", {hi, lo}, {32'hAA, 32'hBB});

        // Asynchronous reset in the middle of a multiply
        start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        run_op(4'd1, 32'd3, 32'd4);

        // Accumulate ops: real with the macro, ignored without it
        run_op(4'd4, 32'd0, 32'd0);
        run_op(4'd5, 32'd5, 32'd0);
        run_op(4'd6, 32'd3, 32'd4);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
